// File: rtl/mul_pkg.sv
// Shared types and defaults for the repeated-addition multiplier control path.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ACCUM,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// Accumulate-cycle counter: synchronous clear/increment, terminal flag at MAX_ITER-1.
module mul_iter_cnt
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH    = MUL_WIDTH,
  parameter int unsigned MAX_ITER = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MAX_ITER - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier: load A, load B / clear P,
// accumulate until B reaches zero, with abort and hang detection.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH    = MUL_WIDTH,
  parameter int unsigned MAX_ITER = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             eqz,
  output logic             ld_A,
  output logic             ld_B,
  output logic             load_P,
  output logic             clear_p,
  output logic             dec_B,
  output logic             busy,
  output logic             done,
  output logic             hang,
  output logic [WIDTH-1:0] iter_cnt
);

  mul_state_t state_q, state_d;
  logic       cnt_clr, cnt_inc, cnt_term;

  mul_iter_cnt #(
    .WIDTH    (WIDTH),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (iter_cnt),
    .term_o (cnt_term)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Mealy strobes; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    ld_A    = 1'b0;
    ld_B    = 1'b0;
    load_P  = 1'b0;
    clear_p = 1'b0;
    dec_B   = 1'b0;
    done    = 1'b0;
    hang    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          cnt_clr = 1'b1;
        end
      end
      LOAD_A: begin
        ld_A    = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        ld_B    = 1'b1;
        clear_p = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (eqz) begin
          state_d = DONE;
        end else begin
          load_P  = 1'b1;
          dec_B   = 1'b1;
          cnt_inc = 1'b1;
          // The last permitted accumulate still lands; the run then ends as hung.
          if (cnt_term) begin
            hang    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      ld_A    = 1'b0;
      ld_B    = 1'b0;
      load_P  = 1'b0;
      clear_p = 1'b0;
      dec_B   = 1'b0;
      done    = 1'b0;
      hang    = 1'b0;
      cnt_inc = 1'b0;
      state_d = IDLE;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural A/B/P datapath plus a cycle-schedule reference model.
module tb_mul_ctrl;

  localparam int unsigned W    = 16;
  localparam int unsigned MAXI = 8;

  logic         clk = 1'b0;
  logic         rst, start, abort, eqz, tie0;
  logic         ld_A, ld_B, load_P, clear_p, dec_B, busy, done, hang;
  logic [W-1:0] iter_cnt;
  logic [W-1:0] a_op, b_op, A_r, B_r, P_r;
  logic [7:0]   obs;

  int checks = 0;
  int errors = 0;

  mul_ctrl #(.WIDTH(W), .MAX_ITER(MAXI)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .eqz      (eqz),
    .ld_A     (ld_A),
    .ld_B     (ld_B),
    .load_P   (load_P),
    .clear_p  (clear_p),
    .dec_B    (dec_B),
    .busy     (busy),
    .done     (done),
    .hang     (hang),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: A/B operand registers, P with clear over load.
  always @(posedge clk) begin
    if (ld_A) A_r <= a_op;
    if (ld_B) B_r <= b_op;
    else if (dec_B) B_r <= B_r - 1'b1;
    if (clear_p) P_r <= '0;
    else if (load_P) P_r <= P_r + A_r;
  end

  assign eqz = tie0 ? 1'b0 : (B_r == '0);
  assign obs = {ld_A, ld_B, load_P, clear_p, dec_B, busy, done, hang};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {ld_A,ld_B,load_P,clear_p,dec_B,busy,done,hang} in cycle c of a run
  // whose B operand is beff, with abort raised in cycle ab (0 = never).
  function automatic logic [7:0] exp_vec(input int c, input int beff, input int ab);
    int  k;
    bit  hung;
    logic [7:0] v;
    hung = (beff >= int'(MAXI));
    k    = hung ? int'(MAXI) : beff;
    v    = '0;
    v[2] = 1'b1;
    if (c == ab) return v;
    if (c == 1) v[7] = 1'b1;
    if (c == 2) begin v[6] = 1'b1; v[4] = 1'b1; end
    if (c >= 3 && c < 3 + k) begin v[5] = 1'b1; v[3] = 1'b1; end
    if (!hung && c == 4 + beff) v[1] = 1'b1;
    if (hung && c == 2 + int'(MAXI)) v[0] = 1'b1;
    return v;
  endfunction

  task automatic run(input logic [15:0] a, input int b, input int ab, input bit hold, input bit idle_abort);
    int          beff, endc, k;
    int unsigned n;
    logic [31:0] prod;
    a_op  = a;
    b_op  = b[15:0];
    start = 1'b1;
    abort = idle_abort;
    @(posedge clk); #1;
    start = hold;
    abort = 1'b0;
    beff  = tie0 ? (1 << 30) : b;
    k     = (beff >= int'(MAXI)) ? int'(MAXI) : beff;
    endc  = (ab != 0) ? ab : ((beff < int'(MAXI)) ? 4 + beff : 2 + int'(MAXI));
    for (int c = 1; c <= endc; c++) begin
      abort = (c == ab);
      #1;
      check_eq($sformatf("strobes a=%0h b=%0d cyc=%0d", a, b, c), {24'd0, obs}, {24'd0, exp_vec(c, beff, ab)});
      if (c == 1) check_eq("iter_cleared", {16'd0, iter_cnt}, 32'd0);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    #1;
    check_eq($sformatf("idle_after a=%0h b=%0d", a, b), {24'd0, obs}, 32'd0);
    n    = (ab != 0 && ab - 3 < k) ? ((ab > 3) ? ab - 3 : 0) : k;
    prod = a * n;
    check_eq($sformatf("P a=%0h b=%0d ab=%0d", a, b, ab), {16'd0, P_r}, {16'd0, prod[15:0]});
    check_eq($sformatf("iter a=%0h b=%0d ab=%0d", a, b, ab), {16'd0, iter_cnt}, n);
  endtask

  initial begin
    int b, ab, nat;
    rst = 1'b1; start = 1'b0; abort = 1'b0; tie0 = 1'b0;
    a_op = '0; b_op = '0;
    #12;
    check_eq("reset_outputs", {24'd0, obs}, 32'd0);
    check_eq("reset_iter", {16'd0, iter_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(16'd7, 5, 0, 1'b0, 1'b0);
    run(16'd123, 0, 0, 1'b0, 1'b0);
    run(16'hFFFF, 1, 0, 1'b1, 1'b0);
    run(16'd11, 2, 0, 1'b0, 1'b0);
    run(16'd3, 10, 6, 1'b0, 1'b0);
    run(16'd5, 2, 0, 1'b0, 1'b1);
    run(16'd9, 7, 0, 1'b0, 1'b0);
    run(16'd9, 8, 0, 1'b0, 1'b0);
    tie0 = 1'b1;
    run(16'h1234, 5, 0, 1'b0, 1'b0);
    tie0 = 1'b0;

    // Asynchronous reset between edges in the middle of ACCUM.
    a_op = 16'd9; b_op = 16'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("pre_reset_accum", {24'd0, obs}, {24'd0, exp_vec(4, 6, 0)});
    rst = 1'b1;
    #1;
    check_eq("async_reset_outputs", {24'd0, obs}, 32'd0);
    check_eq("async_reset_iter", {16'd0, iter_cnt}, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_reset_idle", {24'd0, obs}, 32'd0);
    run(16'd2, 3, 0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      b   = int'($urandom_range(0, 10));
      nat = (b < int'(MAXI)) ? 4 + b : 2 + int'(MAXI);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, nat)) : 0;
      run(16'($urandom), b, ab, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Control unit for the repeated-addition multiplier in the adder/multiplier datapath. It takes a start request, sequences the operand registers A and B and the product register P through load, clear and accumulate steps, and reports completion. The block drives the `load_P`/`clear_p` controls of the 16-bit product register and the load/decrement controls of the A/B registers. It watches the datapath's B-equals-zero flag to decide when the product is final.

## Interface
Parameters:
- `WIDTH`, 16: operand/product width; sets the iteration-counter width.
- `MAX_ITER`, 2**WIDTH-1: accumulate-cycle limit before the run is declared hung.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `abort` in 1: cancel the run in progress; ignored in IDLE.
- `eqz` in 1: datapath flag, B register == 0, combinational from B.
- `ld_A` out 1: A captures the operand bus this edge.
- `ld_B` out 1: B captures the operand bus this edge.
- `load_P` out 1: P <= P + A this edge.
- `clear_p` out 1: P <= 0 this edge.
- `dec_B` out 1: B <= B − 1 this edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; P is final.
- `hang` out 1: one-cycle pulse; `MAX_ITER` was reached without `eqz`.
- `iter_cnt` out WIDTH: number of accumulate cycles in the current or last run.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, ACCUM, DONE.
- IDLE:
  - All strobes are 0.
  - `start`=1 → LOAD_A, and `iter_cnt` is cleared to 0 on the same edge.
- LOAD_A: `ld_A`=1 (operand A on the bus) → LOAD_B.
- LOAD_B: `ld_B`=1 and `clear_p`=1 in the same cycle → ACCUM.
- ACCUM, Mealy-gated on `eqz`:
  - `eqz`=0: `load_P`=1, `dec_B`=1, `iter_cnt`+1, stay in ACCUM.
  - `eqz`=1: no strobes → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE. `start` must be seen again in IDLE to begin a new run.
- Hang detection:
  - Applies in ACCUM with `eqz`=0 and `iter_cnt`==`MAX_ITER`−1.
  - On that edge the final accumulate still happens, `hang` pulses, and the FSM goes to IDLE with no `done`.
- `abort`=1 in any non-IDLE state:
  - All strobes are forced to 0 that cycle and the FSM goes to IDLE next edge.
  - No `done`.
  - `iter_cnt` holds its value.
- Simultaneous events:
  - `abort` has priority over `eqz`, over the hang condition, and over normal transitions.
  - `start` outside IDLE is ignored.
- Reset value of every output is 0, and the state is IDLE. Reset mid-run drops to IDLE immediately with all strobes deasserted.
- Strobes are mutually consistent: `ld_A` and `ld_B` are never high together, and `load_P` and `clear_p` are never high together.

## Timing
- Edge 0 samples `start`. `ld_A` is high in cycle 1, `ld_B`/`clear_p` in cycle 2, and ACCUM begins in cycle 3.
- Run latency for operand B=n (n ≥ 0):
  - `done` is high in cycle 4+n after the sampling edge.
  - `busy` is high for cycles 1 through 4+n.
- B=0: ACCUM lasts one cycle with no strobes. `done` is in cycle 4, P=0, `iter_cnt`=0.
- `eqz` must be valid combinationally from the B register within the ACCUM cycle; there is no pipelining on it.
- Back-to-back runs: the earliest next `start` is sampled in the cycle after `done` (in IDLE).

## Structure
- Shared package `mul_pkg`:
  - state enum `mul_state_t` (IDLE, LOAD_A, LOAD_B, ACCUM, DONE);
  - `MUL_WIDTH`=16 default constant.
- Sub-module `mul_iter_cnt` (WIDTH): a counter with synchronous clear and increment, async active-high reset, and a terminal flag at `MAX_ITER`−1. It produces `iter_cnt` and the hang condition.
- The FSM (registered state, combinational outputs) lives in `mul_ctrl`.
- The bench pairs the block with a behavioral A/B/P datapath: P is a 16-bit register with clear priority over load, synchronous, and P <= P + A on `load_P`.

## Test plan
- A=7, B=5, pulse `start`:
  - Expect `ld_A` in cycle 1 and `ld_B`+`clear_p` in cycle 2.
  - Expect five `load_P`/`dec_B` cycles, then `done` in cycle 9.
  - Expect P=35 and `iter_cnt`=5.
- A=123, B=0 → no `load_P`, `done` in cycle 4, P=0, `iter_cnt`=0.
- A=0xFFFF, B=1 → one accumulate, P=0xFFFF, `done` in cycle 5. Then `start` held high through `done` → a second run starts on the edge after `done`.
- Run with A=3, B=10, `abort` in the 4th ACCUM cycle:
  - All strobes go low that cycle, the FSM is in IDLE next cycle, and there is no `done` pulse.
  - `iter_cnt`=3.
  - `abort` asserted in IDLE has no effect.
- `MAX_ITER`=8 with `eqz` tied to 0 → eight `load_P` pulses, `hang` in the 8th ACCUM cycle, then IDLE, `done` never asserted.
- `rst` asserted asynchronously mid-ACCUM (between edges) → all outputs are 0 immediately and the state is IDLE. After release, a fresh A=2, B=3 run yields P=6.
